// File: rtl/perf_pkg.sv
// Shared types and constants for the performance report streamer.
// The header word layout lives here so that any sink-side decoder can
// import the same definition.
package perf_pkg;

  // Report FSM states, in the order the packet words are emitted.
  typedef enum logic [2:0] {
    RPT_IDLE,
    RPT_HDR,
    RPT_BR,
    RPT_IPC,
    RPT_MEM
  } rpt_state_e;

  // Header sync byte and payload word count.
  localparam logic [7:0] RPT_SYNC   = 8'hA5;
  localparam logic [7:0] RPT_NWORDS = 8'h03;

  // Packet word width; every metric counter must fit inside it.
  localparam int RPT_DATA_W = 32;

  // Header word: {sync, sequence number, overrun count, payload words}.
  function automatic logic [RPT_DATA_W-1:0] rpt_hdr(input logic [7:0] seq,
                                                    input logic [7:0] ovr);
    return {RPT_SYNC, seq, ovr, RPT_NWORDS};
  endfunction

endpackage

// File: rtl/perf_tick_gen.sv
// Free-running period counter with an enable. Emits a one-cycle tick on
// the last count of every REPORT_PERIOD-cycle period. Dropping the enable
// clears the count, so a re-enable always starts a full fresh period.
// Reusable by any block that needs a periodic sample strobe.
module perf_tick_gen #(
  parameter int REPORT_PERIOD = 1000,
  parameter int CNT_W         = $clog2(REPORT_PERIOD)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_tick
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REPORT_PERIOD - 1);

  logic [CNT_W-1:0] per_cnt_q;
  logic [CNT_W-1:0] per_cnt_d;
  logic             at_last;

  assign at_last = (per_cnt_q == LAST_CNT);

  // Next count: clear while disabled, wrap on the last count, else step.
  always_comb begin
    per_cnt_d = per_cnt_q;
    if (!i_en) begin
      per_cnt_d = '0;
    end else if (at_last) begin
      per_cnt_d = '0;
    end else begin
      per_cnt_d = per_cnt_q + CNT_W'(1);
    end
  end

  // Period counter register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      per_cnt_q <= '0;
    end else begin
      per_cnt_q <= per_cnt_d;
    end
  end

  // Tick only while enabled; a disabled counter never fires.
  assign o_tick = i_en && at_last;

endmodule

// File: rtl/perf_report_streamer.sv
// Periodically snapshots the three evaluation metrics and streams them out
// as a 4-word packet: header, branch-correct, IPC, memory-penalty.
//
// Handshake: o_rpt_valid, o_rpt_data and o_rpt_last all come straight from
// flops. A word is transferred on a rising clock edge where o_rpt_valid and
// i_rpt_ready are both high; until then the word and its last flag are held
// unchanged. Valid never looks at ready combinationally.
//
// Reports falling due while a packet is still in flight are dropped and
// counted in a saturating overrun counter. The header carries the overrun
// count as it stood when the header was loaded; later overruns show up in
// the next packet.
module perf_report_streamer
  import perf_pkg::*;
#(
  parameter int BR_CNT_W      = 10,
  parameter int IPC_CNT_W     = 10,
  parameter int MEM_PEN_CNT_W = 7,
  parameter int REPORT_PERIOD = 1000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic [BR_CNT_W-1:0]      i_br_correct_eval,
  input  logic [IPC_CNT_W-1:0]     i_ipc_eval,
  input  logic [MEM_PEN_CNT_W-1:0] i_mem_pen,
  output logic                     o_rpt_valid,
  output logic [RPT_DATA_W-1:0]    o_rpt_data,
  output logic                     o_rpt_last,
  input  logic                     i_rpt_ready,
  output logic [7:0]               o_overrun_cnt,
  output logic                     o_busy
);

  // ---------------------------------------------------------------------
  // Report tick
  // ---------------------------------------------------------------------
  logic tick;

  perf_tick_gen #(
    .REPORT_PERIOD(REPORT_PERIOD)
  ) u_tick_gen (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (i_en),
    .o_tick(tick)
  );

  // ---------------------------------------------------------------------
  // State. state_q is the FSM state and the natural probe point for
  // anything watching packet progress.
  // ---------------------------------------------------------------------
  rpt_state_e                state_q,    state_d;
  logic [7:0]                seq_q,      seq_d;
  logic [7:0]                ovr_q,      ovr_d;
  logic [BR_CNT_W-1:0]       snap_br_q,  snap_br_d;
  logic [IPC_CNT_W-1:0]      snap_ipc_q, snap_ipc_d;
  logic [MEM_PEN_CNT_W-1:0]  snap_mem_q, snap_mem_d;
  logic                      valid_q,    valid_d;
  logic [RPT_DATA_W-1:0]     data_q,     data_d;
  logic                      last_q,     last_d;

  logic hs;

  assign hs = valid_q && i_rpt_ready;

  // Next-state, snapshot, counters and the registered word mux.
  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    ovr_d      = ovr_q;
    snap_br_d  = snap_br_q;
    snap_ipc_d = snap_ipc_q;
    snap_mem_d = snap_mem_q;
    valid_d    = valid_q;
    data_d     = data_q;
    last_d     = last_q;

    // A tick while busy is dropped; this includes the MEM handshake cycle.
    if (tick && (state_q != RPT_IDLE) && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end

    unique case (state_q)
      RPT_IDLE: begin
        if (tick) begin
          state_d    = RPT_HDR;
          snap_br_d  = i_br_correct_eval;
          snap_ipc_d = i_ipc_eval;
          snap_mem_d = i_mem_pen;
        end
      end
      RPT_HDR: if (hs) state_d = RPT_BR;
      RPT_BR:  if (hs) state_d = RPT_IPC;
      RPT_IPC: if (hs) state_d = RPT_MEM;
      RPT_MEM: begin
        if (hs) begin
          state_d = RPT_IDLE;
          seq_d   = seq_q + 8'd1;
        end
      end
      default: state_d = RPT_IDLE;
    endcase

    // Output word is reloaded only on a state change, which keeps it
    // frozen while the sink stalls. The header uses the overrun count as
    // it stands now, since no overrun can occur in the IDLE->HDR cycle.
    if (state_d != state_q) begin
      valid_d = (state_d != RPT_IDLE);
      last_d  = (state_d == RPT_MEM);
      unique case (state_d)
        RPT_HDR: data_d = rpt_hdr(seq_q, ovr_q);
        RPT_BR:  data_d = RPT_DATA_W'(snap_br_d);
        RPT_IPC: data_d = RPT_DATA_W'(snap_ipc_d);
        RPT_MEM: data_d = RPT_DATA_W'(snap_mem_d);
        default: data_d = '0;
      endcase
    end
  end

  // All FSM state and registered outputs; async reset clears everything.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= RPT_IDLE;
      seq_q      <= '0;
      ovr_q      <= '0;
      snap_br_q  <= '0;
      snap_ipc_q <= '0;
      snap_mem_q <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      ovr_q      <= ovr_d;
      snap_br_q  <= snap_br_d;
      snap_ipc_q <= snap_ipc_d;
      snap_mem_q <= snap_mem_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      last_q     <= last_d;
    end
  end

  assign o_rpt_valid   = valid_q;
  assign o_rpt_data    = data_q;
  assign o_rpt_last    = last_q;
  assign o_overrun_cnt = ovr_q;
  assign o_busy        = (state_q != RPT_IDLE);

endmodule

// File: tb/tb_perf_report_streamer.sv
// Directed bench for perf_report_streamer: one instance with a 20-cycle
// period and one with a 6-cycle period for the overrun scenario.
module tb_perf_report_streamer;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: REPORT_PERIOD = 20
  logic        rst_a = 1'b1, en_a = 1'b0, rdy_a = 1'b0;
  logic [9:0]  br_a = '0, ipc_a = '0;
  logic [6:0]  mem_a = '0;
  logic        valid_a, last_a, busy_a;
  logic [31:0] data_a;
  logic [7:0]  ovr_a;

  // Instance B: REPORT_PERIOD = 6
  logic        rst_b = 1'b1, en_b = 1'b0, rdy_b = 1'b0;
  logic [9:0]  br_b = '0, ipc_b = '0;
  logic [6:0]  mem_b = '0;
  logic        valid_b, last_b, busy_b;
  logic [31:0] data_b;
  logic [7:0]  ovr_b;

  perf_report_streamer #(.REPORT_PERIOD(20)) dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_en(en_a),
    .i_br_correct_eval(br_a), .i_ipc_eval(ipc_a), .i_mem_pen(mem_a),
    .o_rpt_valid(valid_a), .o_rpt_data(data_a), .o_rpt_last(last_a),
    .i_rpt_ready(rdy_a), .o_overrun_cnt(ovr_a), .o_busy(busy_a)
  );

  perf_report_streamer #(.REPORT_PERIOD(6)) dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_en(en_b),
    .i_br_correct_eval(br_b), .i_ipc_eval(ipc_b), .i_mem_pen(mem_b),
    .o_rpt_valid(valid_b), .o_rpt_data(data_b), .o_rpt_last(last_b),
    .i_rpt_ready(rdy_b), .o_overrun_cnt(ovr_b), .o_busy(busy_b)
  );

  // Vector record: ready to drive after the check, expected outputs.
  typedef struct {
    logic        rdy;
    logic        valid;
    logic [31:0] data;
    logic        last;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  function automatic vec_t mk(input logic r, input logic v,
                              input logic [31:0] d, input logic l);
    vec_t t;
    t.rdy = r; t.valid = v; t.data = d; t.last = l;
    return t;
  endfunction

  // Scoreboard compare
  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Wait (bounded) on negedges until the selected instance raises valid.
  task automatic wait_valid(input bit sel_b, input int limit, output int n);
    n = 0;
    while (!(sel_b ? valid_b : valid_a) && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Apply a cycle table to instance A, one entry per negedge.
  task automatic run_a(input string nm, input vec_t tbl[$], output int hs);
    hs = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("%s[%0d].valid", nm, i), 32'(valid_a), 32'(tbl[i].valid));
      chk($sformatf("%s[%0d].data", nm, i), data_a, tbl[i].data);
      chk($sformatf("%s[%0d].last", nm, i), 32'(last_a), 32'(tbl[i].last));
      if (valid_a && tbl[i].rdy) hs++;
      rdy_a = tbl[i].rdy;
    end
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t basic_v[$];
    vec_t p2_v[$];
    vec_t bp_v[$];
    int   n;
    int   hs;
    int   unstable;

    // Table: basic packet, ready held high
    basic_v.push_back(mk(1, 1, 32'hA500_0003, 0));
    basic_v.push_back(mk(1, 1, 32'd700, 0));
    basic_v.push_back(mk(1, 1, 32'd350, 0));
    basic_v.push_back(mk(1, 1, 32'd42, 1));
    basic_v.push_back(mk(1, 0, 32'd0, 0));
    // Table: second packet, BR input changed to 5 after the tick
    p2_v.push_back(mk(1, 1, 32'hA501_0003, 0));
    p2_v.push_back(mk(1, 1, 32'd700, 0));
    p2_v.push_back(mk(1, 1, 32'd350, 0));
    p2_v.push_back(mk(1, 1, 32'd42, 1));
    p2_v.push_back(mk(1, 0, 32'd0, 0));
    // Table: backpressure, ready 1-0-0-1 repeating
    bp_v.push_back(mk(1, 1, 32'hA502_0003, 0));
    bp_v.push_back(mk(0, 1, 32'd5, 0));
    bp_v.push_back(mk(0, 1, 32'd5, 0));
    bp_v.push_back(mk(1, 1, 32'd5, 0));
    bp_v.push_back(mk(1, 1, 32'd350, 0));
    bp_v.push_back(mk(0, 1, 32'd42, 1));
    bp_v.push_back(mk(0, 1, 32'd42, 1));
    bp_v.push_back(mk(1, 1, 32'd42, 1));
    bp_v.push_back(mk(1, 0, 32'd0, 0));

    // Reset state
    #1;
    chk("rst.valid", 32'(valid_a), 32'd0);
    chk("rst.data", data_a, 32'd0);
    chk("rst.last", 32'(last_a), 32'd0);
    chk("rst.busy", 32'(busy_a), 32'd0);
    chk("rst.ovr", 32'(ovr_a), 32'd0);

    // Basic packet: tick on the 20th enabled edge
    @(negedge clk);
    rst_a = 1'b0; en_a = 1'b1; rdy_a = 1'b1;
    br_a = 10'd700; ipc_a = 10'd350; mem_a = 7'd42;
    wait_valid(0, 40, n);
    chk("first_tick_latency", n, 20);
    chk("hdr.busy", 32'(busy_a), 32'd1);
    run_a("basic", basic_v, hs);
    chk("basic.handshakes", hs, 4);

    // Second packet, input change after the tick
    wait_valid(0, 40, n);
    chk("second_tick_latency", n, 16);
    br_a = 10'd5;
    run_a("midchg", p2_v, hs);

    // Backpressure packet
    wait_valid(0, 40, n);
    chk("third_tick_latency", n, 16);
    run_a("bp", bp_v, hs);
    chk("bp.handshakes", hs, 4);

    // Enable gating at per_cnt = 15
    repeat (7) @(negedge clk);
    en_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("gate[%0d].valid", i), 32'(valid_a), 32'd0);
    end
    en_a = 1'b1;
    wait_valid(0, 40, n);
    chk("reenable_latency", n, 20);
    chk("gate.hdr", data_a, 32'hA503_0003);

    // Async reset during the IPC word
    @(negedge clk);
    chk("pre_rst.br", data_a, 32'd5);
    @(negedge clk);
    chk("pre_rst.ipc", data_a, 32'd350);
    #1 rst_a = 1'b1;
    #1;
    chk("async_rst.valid", 32'(valid_a), 32'd0);
    chk("async_rst.data", data_a, 32'd0);
    chk("async_rst.last", 32'(last_a), 32'd0);
    chk("async_rst.busy", 32'(busy_a), 32'd0);
    chk("async_rst.ovr", 32'(ovr_a), 32'd0);
    @(negedge clk);
    rst_a = 1'b0;
    wait_valid(0, 40, n);
    chk("post_rst_latency", n, 20);
    chk("post_rst.hdr", data_a, 32'hA500_0003);

    // Overrun on instance B (period 6), ready held low
    @(negedge clk);
    rst_b = 1'b0; en_b = 1'b1; rdy_b = 1'b0;
    br_b = 10'd100; ipc_b = 10'd200; mem_b = 7'd50;
    wait_valid(1, 20, n);
    chk("b.tick_latency", n, 6);
    chk("b.hdr", data_b, 32'hA500_0003);
    br_b = 10'd1; ipc_b = 10'd2; mem_b = 7'd3;
    unstable = 0;
    repeat (19) begin
      @(negedge clk);
      if (!valid_b || data_b !== 32'hA500_0003 || last_b) unstable++;
    end
    chk("b.stall_unstable_cycles", unstable, 0);
    chk("b.ovr", 32'(ovr_b), 32'd3);
    rdy_b = 1'b1;
    @(negedge clk);
    chk("b.br", data_b, 32'd100);
    @(negedge clk);
    chk("b.ipc", data_b, 32'd200);
    @(negedge clk);
    chk("b.mem", data_b, 32'd50);
    chk("b.mem.last", 32'(last_b), 32'd1);
    @(negedge clk);
    chk("b.idle.valid", 32'(valid_b), 32'd0);
    @(negedge clk);
    chk("b.next.valid", 32'(valid_b), 32'd1);
    chk("b.next.hdr", data_b, 32'hA501_0303);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
